// File: rtl/vram_pkg.sv
// Shared beam-timing constants and scheduler state encoding for the VRAM access scheduler.
package vram_pkg;
  localparam int unsigned H_DISPLAY = 256;
  localparam int unsigned H_MAX     = 308;
  localparam int unsigned V_DISPLAY = 240;
  localparam int unsigned V_MAX     = 261;
  localparam int unsigned VRAM_AW   = 10;
  localparam int unsigned VRAM_DW   = 8;
  localparam int unsigned N_REQ     = 2;

  // Last in-line fetch (col 31) and the late fetch of col 0 for the following line.
  localparam int unsigned H_LAST_FETCH = H_DISPLAY - 11;
  localparam int unsigned H_WRAP_FETCH = H_MAX - 3;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StVid  = 2'd1;
  localparam logic [1:0] StGnt0 = 2'd2;
  localparam logic [1:0] StGnt1 = 2'd3;

  function automatic logic [VRAM_AW-1:0] tile_addr(input logic [4:0] row,
                                                   input logic [4:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so ties go to the other side.
module rr_arbiter2
  import vram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);
  logic ptr_q;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b1;
    end else if (gnt != '0) begin
      ptr_q <= gnt[1];
    end
  end
endmodule

// File: rtl/vram_scheduler.sv
// Shares one VRAM port between the tile fetcher (fixed beam slots) and two round-robin requesters.
module vram_scheduler
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         hpos,
  input  logic [8:0]         vpos,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic               ram_we,
  output logic [VRAM_DW-1:0] ram_wdata,
  input  logic [VRAM_DW-1:0] ram_rdata,
  output logic [VRAM_DW-1:0] tile_code,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_we,
  input  logic [VRAM_AW-1:0] req_addr0,
  input  logic [VRAM_AW-1:0] req_addr1,
  input  logic [VRAM_DW-1:0] req_wdata0,
  input  logic [VRAM_DW-1:0] req_wdata1,
  output logic [N_REQ-1:0]   ack,
  output logic               rd_valid,
  output logic [VRAM_DW-1:0] rd_data,
  output logic               rd_id
);
  logic [8:0]         next_line;
  logic               vid_line, vid_wrap, vid_slot;
  logic [VRAM_AW-1:0] vid_addr;
  logic [N_REQ-1:0]   gnt;
  logic [1:0]         state_d, state_q;
  logic               live_q;
  logic [VRAM_AW-1:0] ram_addr_q;
  logic               ram_we_q;
  logic [VRAM_DW-1:0] ram_wdata_q, tile_q, rd_data_q;
  logic [N_REQ-1:0]   ack_q;
  logic               vid_p2_q, rd_p2_q, rd_id_p2_q;
  logic               rd_valid_q, rd_id_q;

  assign next_line = (vpos == 9'(V_MAX)) ? 9'd0 : vpos + 9'd1;
  assign vid_line  = (vpos < 9'(V_DISPLAY)) && (hpos[2:0] == 3'd5) &&
                     (hpos <= 9'(H_LAST_FETCH));
  assign vid_wrap  = (hpos == 9'(H_WRAP_FETCH)) && (next_line < 9'(V_DISPLAY));
  assign vid_slot  = vid_line || vid_wrap;
  assign vid_addr  = vid_wrap ? tile_addr(next_line[7:3], 5'd0)
                              : tile_addr(vpos[7:3], hpos[7:3] + 5'd1);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (live_q && !vid_slot),
    .req   (req),
    .gnt   (gnt)
  );

  // The first edge after reset release only arms the scheduler; decisions start one cycle later.
  always_comb begin
    state_d = StIdle;
    if (live_q) begin
      if (vid_slot) begin
        state_d = StVid;
      end else if (gnt[0]) begin
        state_d = StGnt0;
      end else if (gnt[1]) begin
        state_d = StGnt1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q      <= 1'b0;
      state_q     <= StIdle;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      ack_q       <= '0;
      vid_p2_q    <= 1'b0;
      rd_p2_q     <= 1'b0;
      rd_id_p2_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_id_q     <= 1'b0;
      tile_q      <= '0;
    end else begin
      live_q   <= 1'b1;
      state_q  <= state_d;
      ack_q    <= gnt;
      ram_we_q <= 1'b0;
      unique case (state_d)
        StVid: ram_addr_q <= vid_addr;
        StGnt0: begin
          ram_addr_q <= req_addr0;
          ram_we_q   <= req_we[0];
          if (req_we[0]) ram_wdata_q <= req_wdata0;
        end
        StGnt1: begin
          ram_addr_q <= req_addr1;
          ram_we_q   <= req_we[1];
          if (req_we[1]) ram_wdata_q <= req_wdata1;
        end
        default: ;
      endcase
      // RAM sees the command this cycle; its read data is captured one cycle later.
      vid_p2_q   <= (state_q == StVid);
      rd_p2_q    <= ((state_q == StGnt0) || (state_q == StGnt1)) && !ram_we_q;
      rd_id_p2_q <= (state_q == StGnt1);
      rd_valid_q <= rd_p2_q;
      if (rd_p2_q) begin
        rd_data_q <= ram_rdata;
        rd_id_q   <= rd_id_p2_q;
      end
      if (vid_p2_q) tile_q <= ram_rdata;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign ack       = ack_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_id     = rd_id_q;
  assign tile_code = tile_q;
endmodule

// File: tb/tb_vram_scheduler.sv
// Bench for vram_scheduler: synchronous VRAM model plus a slot-level reference of the access rules.
module tb_vram_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       preload = 1'b1;
  logic [8:0] hpos = 9'd0;
  logic [8:0] vpos = 9'd250;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata, tile_code, rd_data;
  logic [1:0] req = 2'b00, req_we = 2'b00, ack;
  logic [9:0] req_addr0 = '0, req_addr1 = '0;
  logic [7:0] req_wdata0 = '0, req_wdata1 = '0;
  logic       rd_valid, rd_id;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];

  typedef struct { bit rd; bit vid; bit id; logic [7:0] data; } pipe_t;
  pipe_t p0, p1;
  bit         warm;
  int         last_gnt;
  logic [1:0] exp_ack;
  logic       exp_we, exp_rd_valid, exp_rd_id;
  logic [9:0] exp_addr;
  logic [7:0] exp_wdata, exp_rd_data, exp_tile;

  vram_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .tile_code  (tile_code),
    .req        (req),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .ack        (ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_id      (rd_id)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM: read data appears the cycle after the address is presented.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    p0 = '{1'b0, 1'b0, 1'b0, 8'h00};
    p1 = p0;
    warm = 1'b0;
    last_gnt = 1;
    exp_ack = '0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_rd_valid = 1'b0; exp_rd_data = '0; exp_rd_id = 1'b0; exp_tile = '0;
  endtask

  // Wait for the next negedge and work out what the decision just registered must look like.
  task automatic tick();
    pipe_t ne, vis;
    int h, v, nl, g;
    @(negedge clk);
    if (reset) begin
      model_reset();
      return;
    end
    ne = '{1'b0, 1'b0, 1'b0, 8'h00};
    exp_ack = '0;
    exp_we = 1'b0;
    h = int'(hpos);
    v = int'(vpos);
    nl = (v == 261) ? 0 : v + 1;
    if (!warm) begin
      warm = 1'b1;
    end else if ((v < 240 && h % 8 == 5 && h <= 245) || (h == 305 && nl < 240)) begin
      exp_addr = (h == 305) ? 10'((nl / 8) * 32) : 10'((v / 8) * 32 + h / 8 + 1);
      ne.vid = 1'b1;
      ne.data = ref_mem[exp_addr];
    end else if (req != 2'b00) begin
      g = (req == 2'b11) ? 1 - last_gnt : (req[0] ? 0 : 1);
      last_gnt = g;
      exp_ack[g] = 1'b1;
      exp_addr = (g == 1) ? req_addr1 : req_addr0;
      if (req_we[g]) begin
        exp_we = 1'b1;
        exp_wdata = (g == 1) ? req_wdata1 : req_wdata0;
        ref_mem[exp_addr] = exp_wdata;
      end else begin
        ne.rd = 1'b1;
        ne.id = (g == 1);
        ne.data = ref_mem[exp_addr];
      end
    end
    vis = p1;
    p1 = p0;
    p0 = ne;
    exp_rd_valid = vis.rd;
    if (vis.rd) begin
      exp_rd_data = vis.data;
      exp_rd_id = vis.id;
    end
    if (vis.vid) exp_tile = vis.data;
  endtask

  task automatic advance_beam();
    if (hpos == 9'd308) begin
      hpos = 9'd0;
      vpos = (vpos == 9'd261) ? 9'd0 : vpos + 9'd1;
    end else begin
      hpos = hpos + 9'd1;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({ram_addr, ram_we, ram_wdata, tile_code, ack, rd_valid, rd_data, rd_id} !== 39'd0)
      begin n_fail++; $display("FAIL reset_outputs: got %h, want 0",
        {ram_addr, ram_we, ram_wdata, tile_code, ack, rd_valid, rd_data, rd_id}); end
    req = 2'b11;
    repeat (3) begin
      tick();
      n_checks++;
      if (ack !== 2'b00 || ram_we !== 1'b0 || rd_valid !== 1'b0)
        begin n_fail++; $display("FAIL reset_hold: ack=%b we=%b rv=%b, want 0", ack, ram_we,
          rd_valid); end
      advance_beam();
    end
    req = 2'b00;
    preload = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++;
    if (ack !== 2'b00 || ram_we !== 1'b0 || ram_addr !== 10'd0)
      begin n_fail++; $display("FAIL reset_release: ack=%b we=%b addr=%0d, want 0/0/0", ack,
        ram_we, ram_addr); end
    advance_beam();
  endtask

  task automatic test_tile_line();
    int ph, pv;
    hpos = 9'd300;
    vpos = 9'd7;
    repeat (318) begin
      tick();
      ph = (hpos == 9'd308) ? 0 : int'(hpos) + 1;
      pv = (hpos == 9'd308) ? int'(vpos) + 1 : int'(vpos);
      n_checks++;
      if (ram_we !== 1'b0 || ram_addr !== exp_addr)
        begin n_fail++; $display("FAIL tile_cmd h=%0d: we=%b addr=%0d, want 0/%0d", hpos, ram_we,
          ram_addr, exp_addr); end
      if (vpos == 9'd7 && hpos == 9'd305) begin
        n_checks++;
        if (ram_addr !== 10'd32)
          begin n_fail++; $display("FAIL tile_wrap_addr: got %0d, want 32", ram_addr); end
      end
      if (pv == 8 && ph < 256) begin
        n_checks++;
        if (tile_code !== 8'(32 + ph / 8))
          begin n_fail++; $display("FAIL tile_code hpos=%0d: got %0d, want %0d", ph, tile_code,
            32 + ph / 8); end
      end
      advance_beam();
    end
  endtask

  task automatic test_line_end();
    hpos = 9'd240;
    vpos = 9'd239;
    repeat (90) begin
      tick();
      if (vpos == 9'd239 && hpos == 9'd305) begin
        n_checks++;
        if (ram_we !== 1'b0 || ram_addr !== 10'd959)
          begin n_fail++; $display("FAIL last_line_wrap: we=%b addr=%0d, want 0/959", ram_we,
            ram_addr); end
      end
      if ((vpos == 9'd239 && hpos >= 9'd247) || vpos == 9'd240) begin
        n_checks++;
        if (tile_code !== 8'd191)
          begin n_fail++; $display("FAIL blank_tile h=%0d v=%0d: got %0d, want 191", hpos, vpos,
            tile_code); end
      end
      advance_beam();
    end
  endtask

  task automatic test_write_read();
    hpos = 9'd0;
    vpos = 9'd250;
    req_we = 2'b01; req_addr0 = 10'd100; req_wdata0 = 8'hA5; req = 2'b01;
    tick();
    n_checks++;
    if (ack !== 2'b01 || ram_we !== 1'b1 || ram_addr !== 10'd100 || ram_wdata !== 8'hA5)
      begin n_fail++; $display("FAIL write_cmd: ack=%b we=%b addr=%0d data=%h, want 01/1/100/a5",
        ack, ram_we, ram_addr, ram_wdata); end
    req = 2'b00;
    advance_beam();
    tick();
    n_checks++;
    if (ack !== 2'b00 || ram_we !== 1'b0)
      begin n_fail++; $display("FAIL write_single: ack=%b we=%b, want 00/0", ack, ram_we); end
    advance_beam();
    req_we = 2'b00; req = 2'b01;
    tick();
    n_checks++;
    if (ack !== 2'b01 || ram_we !== 1'b0 || ram_addr !== 10'd100)
      begin n_fail++; $display("FAIL read_cmd: ack=%b we=%b addr=%0d, want 01/0/100", ack, ram_we,
        ram_addr); end
    req = 2'b00;
    advance_beam();
    tick();
    n_checks++;
    if (rd_valid !== 1'b0)
      begin n_fail++; $display("FAIL read_early: rd_valid=%b, want 0", rd_valid); end
    advance_beam();
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_id !== 1'b0)
      begin n_fail++; $display("FAIL read_data: rv=%b data=%h id=%b, want 1/a5/0", rd_valid,
        rd_data, rd_id); end
    advance_beam();
    tick();
    n_checks++;
    if (rd_valid !== 1'b0)
      begin n_fail++; $display("FAIL read_pulse: rd_valid=%b, want 0", rd_valid); end
    advance_beam();
  endtask

  task automatic test_contention();
    int prev_id = -1;
    int wt [2] = '{0, 0};
    hpos = 9'd0;
    vpos = 9'd20;
    req_we = 2'b00;
    req_addr0 = 10'($urandom_range(0, 1023));
    req_addr1 = 10'($urandom_range(0, 1023));
    req = 2'b11;
    repeat (160) begin
      tick();
      n_checks++;
      if (ack !== exp_ack)
        begin n_fail++; $display("FAIL contention_ack h=%0d: got %b, want %b", hpos, ack,
          exp_ack); end
      if (hpos[2:0] == 3'd5) begin
        n_checks++;
        if (ack !== 2'b00)
          begin n_fail++; $display("FAIL contention_video h=%0d: ack=%b, want 00", hpos, ack); end
      end
      if (ack == 2'b01 || ack == 2'b10) begin
        if (prev_id >= 0) begin
          n_checks++;
          if (int'(ack[1]) == prev_id)
            begin n_fail++; $display("FAIL contention_alternate: ack=%b repeats winner", ack); end
        end
        prev_id = int'(ack[1]);
      end
      for (int i = 0; i < 2; i++) begin
        wt[i]++;
        n_checks++;
        if (wt[i] > 4)
          begin n_fail++; $display("FAIL contention_latency req%0d: %0d cycles, want <=4", i,
            wt[i]); wt[i] = 0; end
        if (ack[i]) wt[i] = 0;
      end
      n_checks++;
      if (rd_valid !== exp_rd_valid || (exp_rd_valid && rd_id !== exp_rd_id))
        begin n_fail++; $display("FAIL contention_rd: rv=%b id=%b, want %b/%b", rd_valid, rd_id,
          exp_rd_valid, exp_rd_id); end
      if (ack[0]) req_addr0 = 10'($urandom_range(0, 1023));
      if (ack[1]) req_addr1 = 10'($urandom_range(0, 1023));
      advance_beam();
    end
    req = 2'b00;
    repeat (3) begin
      tick();
      advance_beam();
    end
  endtask

  task automatic test_reset_mid_read();
    bit got = 1'b0;
    hpos = 9'd0;
    vpos = 9'd250;
    req_we = 2'b00; req_addr0 = 10'd7; req = 2'b01;
    tick();
    n_checks++;
    if (ack !== 2'b01)
      begin n_fail++; $display("FAIL midreset_ack: got %b, want 01", ack); end
    reset = 1'b1;
    req = 2'b00;
    #1;
    model_reset();
    n_checks++;
    if ({ram_addr, ram_we, ram_wdata, tile_code, ack, rd_valid, rd_data, rd_id} !== 39'd0)
      begin n_fail++; $display("FAIL midreset_outputs: got %h, want 0",
        {ram_addr, ram_we, ram_wdata, tile_code, ack, rd_valid, rd_data, rd_id}); end
    repeat (3) begin
      advance_beam();
      tick();
      n_checks++;
      if (rd_valid !== 1'b0)
        begin n_fail++; $display("FAIL midreset_hold_rv: got %b, want 0", rd_valid); end
    end
    reset = 1'b0;
    repeat (2) begin
      advance_beam();
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || ack !== 2'b00)
        begin n_fail++; $display("FAIL midreset_release: rv=%b ack=%b, want 0/00", rd_valid,
          ack); end
    end
    advance_beam();
    req = 2'b11;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      if (ack != 2'b00) begin
        got = 1'b1;
        n_checks++;
        if (ack !== 2'b01)
          begin n_fail++; $display("FAIL midreset_first_grant: got %b, want 01", ack); end
        req = 2'b00;
      end
      advance_beam();
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL midreset_no_grant: ack=00 after 6 cycles, want a grant");
      req = 2'b00;
    end
    repeat (4) begin
      tick();
      advance_beam();
    end
  endtask

  task automatic test_random();
    int wt [2] = '{0, 0};
    logic [9:0] a;
    logic [7:0] d;
    for (int blk = 0; blk < 4; blk++) begin
      hpos = 9'($urandom_range(0, 308));
      vpos = 9'($urandom_range(0, 261));
      repeat (700) begin
        tick();
        n_checks++;
        if (ack !== exp_ack || ram_we !== exp_we || ram_addr !== exp_addr)
          begin n_fail++; $display("FAIL rand_cmd h=%0d v=%0d: ack=%b we=%b addr=%0d, want %b/%b/%0d",
            hpos, vpos, ack, ram_we, ram_addr, exp_ack, exp_we, exp_addr); end
        n_checks++;
        if (ram_wdata !== exp_wdata)
          begin n_fail++; $display("FAIL rand_wdata: got %h, want %h", ram_wdata, exp_wdata); end
        n_checks++;
        if (rd_valid !== exp_rd_valid ||
            (exp_rd_valid && (rd_data !== exp_rd_data || rd_id !== exp_rd_id)))
          begin n_fail++; $display("FAIL rand_rd: rv=%b data=%h id=%b, want %b/%h/%b", rd_valid,
            rd_data, rd_id, exp_rd_valid, exp_rd_data, exp_rd_id); end
        n_checks++;
        if (tile_code !== exp_tile)
          begin n_fail++; $display("FAIL rand_tile: got %h, want %h", tile_code, exp_tile); end
        for (int i = 0; i < 2; i++) begin
          if (req[i]) begin
            wt[i]++;
            n_checks++;
            if (wt[i] > 4)
              begin n_fail++; $display("FAIL rand_latency req%0d: %0d cycles, want <=4", i,
                wt[i]); wt[i] = 0; end
          end
          if (ack[i]) begin
            req[i] = 1'b0;
            wt[i] = 0;
          end
          if (!req[i] && $urandom_range(0, 2) == 0) begin
            a = 10'($urandom_range(0, 63));
            d = 8'($urandom);
            req_we[i] = 1'($urandom_range(0, 1));
            if (i == 0) begin req_addr0 = a; req_wdata0 = d; end
            else begin req_addr1 = a; req_wdata1 = d; end
            req[i] = 1'b1;
          end
        end
        advance_beam();
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i);
    test_reset();
    test_tile_line();
    test_line_end();
    test_write_read();
    test_contention();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_scheduler.md
VRAM_SCHEDULER -- requirements
Module: vram_scheduler

Interface
REQ-001 clk  in  1  single system clock; all state changes on posedge clk.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 hpos  in  9  beam horizontal position from sync generator, 0..308.
REQ-004 vpos  in  9  beam vertical position from sync generator, 0..261.
REQ-005 ram_addr  out  10  registered VRAM address, tile index = row*32 + col.
REQ-006 ram_we  out  1  registered VRAM write enable.
REQ-007 ram_wdata  out  8  registered VRAM write data.
REQ-008 ram_rdata  in  8  VRAM read data, valid two cycles after the decision cycle.
REQ-009 tile_code  out  8  tile code for current 8-pixel column, stable hpos[2:0]==0..7.
REQ-010 req  in  2  per-requester access request; held high until ack.
REQ-011 req_we  in  2  per-requester write (1) / read (0).
REQ-012 req_addr0, req_addr1  in  10 each  requester addresses.
REQ-013 req_wdata0, req_wdata1  in  8 each  requester write data.
REQ-014 ack  out  2  one-cycle grant pulse, one-hot.
REQ-015 rd_valid  out  1  one-cycle pulse, rd_data holds requester read result.
REQ-016 rd_data  out  8  registered read data; rd_id  out  1  requester owning rd_data.

Function
REQ-017 Three-stage pipeline: decision cycle N -> ram_* registered at end of N -> RAM sees command in N+1 -> ram_rdata captured at end of N+2.
REQ-018 Video decision cycles: vpos<240, hpos[2:0]==5, hpos<=245 -> read col hpos[7:3]+1, row vpos[7:3].
REQ-019 Extra video decision at hpos==305 -> read col 0, row of next line (vpos+1, or 0 when vpos==261); skipped if next line >=240.
REQ-020 Video read data loads tile_code at end of N+2, so new code is valid from hpos[2:0]==0 of the target column.
REQ-021 Video cycles always win; ram_we SHALL be 0 for every video command.
REQ-022 Non-video decision cycles: serve requesters; if both req high, grant the one not granted last (round-robin pointer); if one, grant it; if none, ram_we=0, ram_addr unchanged.
REQ-023 Granted requester: ack[i] high in N+1 (same cycle RAM sees command); pointer updates to i.
REQ-024 Granted read: rd_valid=1, rd_id=i, rd_data=ram_rdata at N+2 (one cycle after ack).
REQ-025 Granted write: ram_we=1 for exactly cycle N+1; no rd_valid.
REQ-026 A requester SHALL receive ack within 4 cycles of asserting req (worst case: one video slot plus one other grant).
REQ-027 Requester holding req after ack is treated as a new request; back-to-back grants to one requester allowed when the other is idle.
REQ-028 tile_code unchanged outside video fetch completion (blanking, vpos>=240).
REQ-029 State machine per decision cycle: IDLE, VID, GNT0, GNT1; next state chosen combinationally from hpos/vpos/req/pointer, registered.

Reset
REQ-030 Reset SHALL immediately force ram_we=0, ram_addr=0, ram_wdata=0, ack=0, rd_valid=0, rd_data=0, rd_id=0, tile_code=0, state=IDLE, pointer=1 (requester 0 first).
REQ-031 Reset mid-access SHALL discard in-flight commands; no ack or rd_valid issued for them after release.
REQ-032 First decision after release is the cycle following the first posedge with reset low.

Structure
REQ-033 Shared package vram_pkg: H_DISPLAY=256, H_MAX=308, V_DISPLAY=240, V_MAX=261, VRAM_AW=10, VRAM_DW=8, N_REQ=2, state enumeration.
REQ-034 One sub-module rr_arbiter2 (2-way round-robin with pointer, enable input from video-slot logic); all other logic in vram_scheduler.

Verification
REQ-035 Drive hpos/vpos sequence of line vpos=8, VRAM preloaded addr=row*32+col -> tile_code==32+col at every hpos with hpos[7:3]==col, col 0..31.
REQ-036 vpos=7, hpos=305 -> ram_addr==32 at hpos=306, tile_code==VRAM[32] at hpos=0 of vpos=8; vpos=239, hpos=305 -> no command issued.
REQ-037 req[0] write addr=100 data=0xA5 during blanking -> ack[0] 1 cycle later, ram_we=1 with ram_addr=100; then read addr=100 -> rd_valid with rd_data=0xA5, rd_id=0.
REQ-038 Both req held continuously during display -> acks alternate 0,1,0,1, no ack at hpos[2:0]==6 commands, each ack within 4 cycles.
REQ-039 Assert reset between ack and rd_valid of a read -> rd_valid never pulses; all outputs 0; after release, req[0] granted first when both request.
